// File: rtl/sd_read_sequencer_pkg.sv
// Shared definitions for the SD read sequencer: 3-bit state encodings,
// the default timing for a 50 MHz clk, and a saturating counter helper.
package sd_read_sequencer_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RESET      = 3'd1;
    localparam logic [2:0] ST_WAIT_FOUND = 3'd2;
    localparam logic [2:0] ST_STREAM     = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;
    localparam logic [2:0] ST_ERROR      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_RESET      = ST_RESET,
        S_WAIT_FOUND = ST_WAIT_FOUND,
        S_STREAM     = ST_STREAM,
        S_DONE       = ST_DONE,
        S_ERROR      = ST_ERROR
    } state_t;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_FOUND_TIMEOUT = 50_000_000;  // 1 s at 50 MHz
    localparam int DEF_IDLE_TIMEOUT  = 1_000_000;   // 20 ms at 50 MHz
    localparam int DEF_FIFO_AW       = 11;
    localparam int DEF_MAX_RETRY     = 3;

    typedef logic [7:0] byte_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sd_read_sequencer_if.sv
// Consumer-side byte stream of the SD read sequencer (valid/ready, FWFT head).
interface sd_read_sequencer_if;
    import sd_read_sequencer_pkg::*;

    logic  o_valid;
    logic  o_ready;
    byte_t o_data;

    modport master (output o_valid, output o_data, input o_ready);
    modport slave  (input o_valid, input o_data, output o_ready);
endinterface

// File: rtl/sd_seq_fifo.sv
// First-word fall-through byte FIFO; the head byte lives in its own register
// so o_dout is stable while the consumer stalls.
module sd_seq_fifo
    import sd_read_sequencer_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic  clk,
    input  logic  rstn,
    input  logic  i_clear,
    input  logic  i_push,
    input  byte_t i_din,
    input  logic  i_pop,
    output byte_t o_dout,
    output logic  o_full,
    output logic  o_empty
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    byte_t       r_mem [DEPTH];
    byte_t       r_dout;
    logic [AW:0] r_wr, r_rd;
    logic [AW:0] w_rd_nxt;
    logic        w_push_ok, w_pop_ok;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign w_rd_nxt  = r_rd + PTR_ONE;
    assign o_dout    = r_dout;

    always_ff @(posedge clk) begin
        if (w_push_ok && !i_clear) r_mem[r_wr[AW-1:0]] <= i_din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_dout <= '0;
        end else if (i_clear) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_dout <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + PTR_ONE;
            if (w_pop_ok)  r_rd <= w_rd_nxt;
            // Head reloads from the incoming byte when the FIFO is (or is about to be) empty,
            // otherwise from the next stored entry.
            if (o_empty || (w_pop_ok && (w_rd_nxt == r_wr))) begin
                if (w_push_ok) r_dout <= i_din;
            end else if (w_pop_ok) begin
                r_dout <= r_mem[w_rd_nxt[AW-1:0]];
            end
        end
    end
endmodule

// File: rtl/sd_read_sequencer.sv
// One SD file-read session: reader reset, file_found supervision, idle-gap EOF and
// FIFO buffering. Optional SD_SEQ_AUTO_RETRY_EN retries a missing file_found.
module sd_read_sequencer
    import sd_read_sequencer_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int FOUND_TIMEOUT = DEF_FOUND_TIMEOUT,
    parameter int IDLE_TIMEOUT  = DEF_IDLE_TIMEOUT,
    parameter int FIFO_AW       = DEF_FIFO_AW,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    output logic                       reader_rstn,
    input  logic                       file_found,
    input  logic                       in_en,
    input  byte_t                      in_byte,
    sd_read_sequencer_if.master        cons,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       overflow,
    output logic [31:0]                byte_count
);
`ifdef SD_SEQ_AUTO_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    state_t      r_state, w_state_nxt;
    logic [31:0] r_cnt, r_bcnt;
    logic [7:0]  r_retry;
    logic        r_seen, r_reader_rstn, r_ovf;
    logic        w_enter_rst, w_start_ok, w_retry;
    logic        w_push, w_pop, w_acc, w_full, w_empty;

    assign w_push = in_en && ((r_state == S_WAIT_FOUND) || (r_state == S_STREAM));
    assign w_pop  = cons.o_ready && !w_empty;
    assign w_acc  = w_push && (!w_full || w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_enter_rst = 1'b0;
        w_start_ok  = 1'b0;
        w_retry     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_state_nxt = S_RESET;
                    w_enter_rst = 1'b1;
                    w_start_ok  = 1'b1;
                end
            end
            S_RESET: begin
                if (r_cnt == 32'(RST_CYCLES - 1)) w_state_nxt = S_WAIT_FOUND;
            end
            S_WAIT_FOUND: begin
                if (file_found || in_en) begin
                    w_state_nxt = S_STREAM;
                end else if (r_cnt == 32'(FOUND_TIMEOUT - 1)) begin
                    if (RETRY_EN && (r_retry < 8'(MAX_RETRY))) begin
                        w_state_nxt = S_RESET;
                        w_enter_rst = 1'b1;
                        w_retry     = 1'b1;
                    end else begin
                        w_state_nxt = S_ERROR;
                    end
                end
            end
            S_STREAM: begin
                if (!in_en && r_seen && (r_cnt == 32'(IDLE_TIMEOUT - 1))) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_reader_rstn <= 1'b0;
            r_cnt         <= '0;
            r_seen        <= 1'b0;
            r_ovf         <= 1'b0;
            r_bcnt        <= '0;
            r_retry       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_reader_rstn <= (w_state_nxt == S_WAIT_FOUND) || (w_state_nxt == S_STREAM) ||
                             (w_state_nxt == S_DONE);
            // One timer serves reset length, found timeout and the idle gap.
            if ((w_state_nxt != r_state) || w_push)
                r_cnt <= '0;
            else if ((r_state == S_RESET) || (r_state == S_WAIT_FOUND) ||
                     ((r_state == S_STREAM) && r_seen))
                r_cnt <= r_cnt + 32'd1;
            if (w_enter_rst) begin
                r_seen <= 1'b0;
                r_ovf  <= 1'b0;
                r_bcnt <= '0;
            end else begin
                if (w_push)          r_seen <= 1'b1;
                if (w_push && !w_acc) r_ovf <= 1'b1;
                if (w_acc)           r_bcnt <= sat_inc(r_bcnt);
            end
            if (w_start_ok)   r_retry <= '0;
            else if (w_retry) r_retry <= r_retry + 8'd1;
        end
    end

    sd_seq_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_clear (w_enter_rst),
        .i_push  (w_push),
        .i_din   (in_byte),
        .i_pop   (cons.o_ready),
        .o_dout  (cons.o_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign cons.o_valid = !w_empty;
    assign reader_rstn  = r_reader_rstn;
    assign busy         = (r_state == S_RESET) || (r_state == S_WAIT_FOUND) || (r_state == S_STREAM);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERROR);
    assign overflow     = r_ovf;
    assign byte_count   = r_bcnt;
endmodule
